output_writeback: RTL and testbench

- Sits directly upstream of the output register bank. It turns the compute core's accumulator stream into register writes (wr_data / wr_addr / wr_en).
- For each run, it accepts exactly NUM_OUT accumulator results over a valid/ready handshake.
- Each result is quantized: shift right with round-half-up, saturate to signed OUT_W, then optional ReLU.
- Results are written to addresses 0..NUM_OUT-1 in order, and done is signalled after the last write.

---
 rtl/output_wb_pkg.sv | 13 +
 rtl/output_writeback_quantize.sv | 27 ++
 rtl/output_writeback.sv | 70 +++++++
 tb/tb_output_writeback.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/output_wb_pkg.sv
// output_wb_pkg: shared state type, default widths and saturation-limit helpers for output_writeback
package output_wb_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} wb_state_t;
  localparam int ACC_W_D = 32;
  localparam int OUT_W_D = 16;
  localparam int ADDR_W_D = 2;
  function automatic longint sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction
  function automatic longint sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction
endpackage

// File: rtl/output_writeback_quantize.sv
// acc_quantize: acc -> round-half-up shift, saturate to signed OUT_W (sat), optional ReLU -> y
module acc_quantize
  import output_wb_pkg::*;
#(
  parameter int ACC_W = ACC_W_D,
  parameter int OUT_W = OUT_W_D,
  parameter int FRAC_SHIFT = 8
) (
  input  logic [ACC_W-1:0] acc,
  input  logic             relu,
  output logic [OUT_W-1:0] y,
  output logic             sat
);
  localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(1) << (FRAC_SHIFT - 1);
  localparam logic signed [ACC_W:0] MAXV = (ACC_W + 1)'(sat_max(OUT_W));
  localparam logic signed [ACC_W:0] MINV = (ACC_W + 1)'(sat_min(OUT_W));
  logic signed [ACC_W:0] r, s;
  logic hi, lo;
  logic [OUT_W-1:0] y_sat;
  assign r = $signed({acc[ACC_W-1], acc}) + HALF;
  assign s = r >>> FRAC_SHIFT;
  assign hi = s > MAXV;
  assign lo = s < MINV;
  assign sat = hi | lo;
  assign y_sat = hi ? MAXV[OUT_W-1:0] : lo ? MINV[OUT_W-1:0] : s[OUT_W-1:0];
  assign y = (relu && y_sat[OUT_W-1]) ? '0 : y_sat;
endmodule

// File: rtl/output_writeback.sv
// output_writeback: accepts NUM_OUT acc results per start, writes quantized data to addr 0..NUM_OUT-1, pulses done, sticky sat_flag
module output_writeback
  import output_wb_pkg::*;
#(
  parameter int ACC_W = ACC_W_D,
  parameter int OUT_W = OUT_W_D,
  parameter int NUM_OUT = 3,
  parameter int ADDR_W = ADDR_W_D,
  parameter int FRAC_SHIFT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              relu_en,
  input  logic [ACC_W-1:0]  acc_in,
  input  logic              acc_valid,
  output logic              acc_ready,
  output logic [OUT_W-1:0]  wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic              busy,
  output logic              done,
  output logic              sat_flag
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_OUT - 1);
  wb_state_t state;
  logic [ADDR_W-1:0] count;
  logic relu_q, q_sat;
  logic [OUT_W-1:0] q_y;
  acc_quantize #(.ACC_W(ACC_W), .OUT_W(OUT_W), .FRAC_SHIFT(FRAC_SHIFT)) u_q (
    .acc(acc_in), .relu(relu_q), .y(q_y), .sat(q_sat)
  );
  assign acc_ready = state == RUN;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      relu_q <= 1'b0;
      wr_data <= '0;
      wr_addr <= '0;
      wr_en <= 1'b0;
      done <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          count <= '0;
          sat_flag <= 1'b0;
          relu_q <= relu_en;
        end
        RUN: if (acc_valid) begin
          wr_data <= q_y;
          wr_addr <= count;
          wr_en <= 1'b1;
          count <= count + 1'b1;
          sat_flag <= sat_flag | q_sat;
          if (count == LAST) begin
            state <= DONE;
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_output_writeback.sv
// tb_output_writeback: table-driven and directed self-checking bench for output_writeback
module tb_output_writeback;
  typedef struct packed {
    logic             relu;
    logic [2:0][31:0] acc;
    logic [2:0][15:0] d;
    logic [2:0]       s;
  } vec_t;
  logic clk = 0, rst = 1, start = 0, relu_en = 0, acc_valid = 0;
  logic [31:0] acc_in = 0;
  logic acc_ready, wr_en, busy, done, sat_flag;
  logic [15:0] wr_data;
  logic [1:0] wr_addr;
  int checks = 0, failures = 0;
  vec_t vecs [3];
  output_writeback dut (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en), .acc_in(acc_in),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .wr_data(wr_data), .wr_addr(wr_addr),
    .wr_en(wr_en), .busy(busy), .done(done), .sat_flag(sat_flag)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic r, input logic [31:0] a0, a1, a2,
                              input logic [15:0] d0, d1, d2, input logic s0, s1, s2);
    vec_t v;
    v.relu = r;
    v.acc = {a2, a1, a0};
    v.d = {d2, d1, d0};
    v.s = {s2, s1, s0};
    return v;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  task automatic step(input logic v, input logic [31:0] a);
    acc_valid = v;
    acc_in = a;
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input logic r);
    start = 1;
    relu_en = r;
    step(0, 0);
    start = 0;
  endtask
  task automatic chk_write(input string n, input int addr, input logic [15:0] d, input logic dn);
    chk({n, "_en"}, wr_en, 1);
    chk({n, "_addr"}, wr_addr, addr);
    chk({n, "_data"}, wr_data, d);
    chk({n, "_done"}, done, dn);
  endtask
  initial begin
    vecs[0] = mk(0, 32'h180, 32'h17F, 32'h80, 16'h0002, 16'h0001, 16'h0001, 0, 0, 0);
    vecs[1] = mk(0, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFF00, 16'h7FFF, 16'h8000, 16'hFFFF, 1, 1, 1);
    vecs[2] = mk(1, 32'hFFFFFF00, 32'h80000000, 32'h300, 16'h0000, 16'h0000, 16'h0003, 0, 1, 1);
    step(0, 0);
    step(0, 0);
    rst = 0;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_ready", acc_ready, 0);
    for (int t = 0; t < 3; t++) begin
      do_start(vecs[t].relu);
      relu_en = ~vecs[t].relu;
      chk($sformatf("v%0d_ready", t), acc_ready, 1);
      chk($sformatf("v%0d_sat_clr", t), sat_flag, 0);
      for (int i = 0; i < 3; i++) begin
        step(1, vecs[t].acc[i]);
        chk_write($sformatf("v%0d_%0d", t, i), i, vecs[t].d[i], i == 2);
        chk($sformatf("v%0d_%0d_sat", t, i), sat_flag, vecs[t].s[i]);
      end
      chk($sformatf("v%0d_done_ready", t), acc_ready, 0);
      step(0, 0);
      chk($sformatf("v%0d_idle_en", t), wr_en, 0);
      chk($sformatf("v%0d_idle_done", t), done, 0);
      chk($sformatf("v%0d_idle_busy", t), busy, 0);
    end
    step(1, 32'h500);
    chk("idle_valid_en", wr_en, 0);
    chk("idle_valid_ready", acc_ready, 0);
    step(1, 32'h500);
    chk("idle_valid_en2", wr_en, 0);
    do_start(0);
    begin
      logic [5:0] pat;
      int k;
      pat = 6'b101001;
      k = 0;
      for (int j = 0; j < 6; j++) begin
        step(pat[j], 32'((k + 1) * 256));
        chk($sformatf("bp%0d_en", j), wr_en, pat[j]);
        if (pat[j]) begin
          chk_write($sformatf("bp%0d", j), k, 16'(k + 1), k == 2);
          k++;
        end else chk($sformatf("bp%0d_ready", j), acc_ready, 1);
      end
    end
    chk("bp_done_ready", acc_ready, 0);
    step(0, 0);
    chk("bp_idle_ready", acc_ready, 0);
    chk("bp_idle_en", wr_en, 0);
    do_start(0);
    step(1, 32'h100);
    chk_write("sb0", 0, 16'h0001, 0);
    start = 1;
    step(0, 0);
    start = 0;
    chk("sb_busy", busy, 1);
    chk("sb_gap_en", wr_en, 0);
    step(1, 32'h200);
    chk_write("sb1", 1, 16'h0002, 0);
    step(1, 32'h300);
    chk_write("sb2", 2, 16'h0003, 1);
    step(0, 0);
    chk("sb_end_done", done, 0);
    chk("sb_end_busy", busy, 0);
    do_start(0);
    step(1, 32'h7FFFFFFF);
    step(1, 32'h7FFFFFFF);
    chk_write("rr1", 1, 16'h7FFF, 0);
    chk("rr_sat", sat_flag, 1);
    rst = 1;
    step(1, 32'h100);
    rst = 0;
    chk("rr_en", wr_en, 0);
    chk("rr_busy", busy, 0);
    chk("rr_sat_clr", sat_flag, 0);
    chk("rr_done", done, 0);
    step(0, 0);
    chk("rr_idle_en", wr_en, 0);
    do_start(0);
    step(1, 32'h200);
    chk_write("rr_new", 0, 16'h0002, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
